// File: rtl/lsq_mem_scheduler_pkg.sv
// Shared types and widths for the LSQ-to-data-memory scheduler.
//   MEM_ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH : bus widths (TAG_WIDTH = log2 of 128 LSQ entries)
//   sched_state_e                           : scheduler FSM states
//   mem_op_t                                : request latched at arbitration and held on the bus
package lsq_mem_scheduler_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned TAG_WIDTH      = 7;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdReq  = 2'd1,
    StRdWait = 2'd2,
    StWrReq  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      we;
  } mem_op_t;

endpackage

// File: rtl/lsq_mem_scheduler_if.sv
// Bundle of the load, store-head, pop and data-memory signals around the scheduler.
//   master : scheduler view (drives ld_ready, load response, pop_queue and the memory request)
//   slave  : LSQ / memory view (drives load requests, store head and memory responses)
interface lsq_mem_scheduler_if;
  import lsq_mem_scheduler_pkg::*;

  // Load request / response
  logic                      ld_valid;
  logic [MEM_ADDR_WIDTH-1:0] ld_addr;
  logic [TAG_WIDTH-1:0]      ld_tag;
  logic                      ld_ready;
  logic                      ld_resp_valid;
  logic [DATA_WIDTH-1:0]     ld_resp_data;
  logic [TAG_WIDTH-1:0]      ld_resp_tag;

  // LSQ head store
  logic                      st_valid;
  logic                      st_commit;
  logic [MEM_ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0]     st_data;
  logic                      pop_queue;

  // Data memory port
  logic                      mem_req;
  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      mem_gnt;
  logic                      mem_rvalid;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport master (
    input  ld_valid, ld_addr, ld_tag,
    output ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag,
    input  st_valid, st_commit, st_addr, st_data,
    output pop_queue,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output ld_valid, ld_addr, ld_tag,
    input  ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag,
    output st_valid, st_commit, st_addr, st_data,
    input  pop_queue,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsq_mem_scheduler_starve_counter.sv
// Saturating count of loads issued while a committed store waits.
//   clk, async_rst : clock, asynchronous active-high reset
//   inc            : count one bypassing load (ignored once saturated)
//   clr            : clear (store issued); wins over inc
//   at_max         : count has reached STARVE_MAX
module lsq_mem_scheduler_starve_counter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic async_rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] MaxVal = CntW'(STARVE_MAX);

  logic [CntW-1:0] cnt_q;

  assign at_max = (cnt_q == MaxVal);

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/lsq_mem_scheduler.sv
// Sequences LSQ loads and the committed head store onto the single data-memory port.
//   clk, async_rst : clock, asynchronous active-high reset
//   clk_en         : 0 freezes all state; pulse outputs read 0 while frozen
//   bus            : load request/response, store head + pop_queue, memory request/response
// One transaction in flight. Loads bypass a waiting committed store at most STARVE_MAX times
// in a row; a load to the store's address never bypasses it.
module lsq_mem_scheduler
  import lsq_mem_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                async_rst,
  input  logic                clk_en,
  lsq_mem_scheduler_if.master bus
);

  sched_state_e          state_q, state_d;
  mem_op_t               op_q, op_d;
  logic                  mem_req_q, mem_req_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;
  logic                  pop_q, pop_d;

  logic st_rdy;
  logic ld_win;
  logic st_win;
  logic at_max;

  assign st_rdy = bus.st_valid & bus.st_commit;

  lsq_mem_scheduler_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .async_rst (async_rst),
    .inc       (clk_en & ld_win & st_rdy),
    .clr       (clk_en & st_win),
    .at_max    (at_max)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    mem_req_d    = mem_req_q;
    tag_d        = tag_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    pop_d        = 1'b0;
    ld_win       = 1'b0;
    st_win       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // During the pop cycle the LSQ head still shows the store just written.
        if (!pop_q) begin
          if (st_rdy && (at_max || (bus.ld_addr == bus.st_addr))) begin
            st_win = 1'b1;
          end else if (bus.ld_valid) begin
            ld_win = 1'b1;
          end else if (st_rdy) begin
            st_win = 1'b1;
          end
        end
        if (ld_win) begin
          op_d.addr  = bus.ld_addr;
          op_d.wdata = '0;
          op_d.we    = 1'b0;
          tag_d      = bus.ld_tag;
          mem_req_d  = 1'b1;
          state_d    = StRdReq;
        end else if (st_win) begin
          op_d.addr  = bus.st_addr;
          op_d.wdata = bus.st_data;
          op_d.we    = 1'b1;
          mem_req_d  = 1'b1;
          state_d    = StWrReq;
        end
      end
      StRdReq: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StRdWait;
        end
      end
      StRdWait: begin
        if (bus.mem_rvalid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = bus.mem_rdata;
          resp_tag_d   = tag_q;
          state_d      = StIdle;
        end
      end
      StWrReq: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          pop_d     = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q      <= StIdle;
      op_q         <= '0;
      mem_req_q    <= 1'b0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      pop_q        <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      op_q         <= op_d;
      mem_req_q    <= mem_req_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      pop_q        <= pop_d;
    end
  end

  // ld_ready is the only combinational output; hidden while reset is held.
  assign bus.ld_ready      = ld_win & clk_en & ~async_rst;
  assign bus.ld_resp_valid = resp_valid_q & clk_en;
  assign bus.ld_resp_data  = resp_data_q;
  assign bus.ld_resp_tag   = resp_tag_q;
  assign bus.pop_queue     = pop_q & clk_en;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = op_q.we;
  assign bus.mem_addr      = op_q.addr;
  assign bus.mem_wdata     = op_q.wdata;

endmodule

// File: tb/tb_lsq_mem_scheduler.sv
module tb_lsq_mem_scheduler;
  import lsq_mem_scheduler_pkg::*;

  logic clk = 1'b0;
  logic async_rst;
  logic clk_en;

  int checks = 0;
  int errors = 0;

  lsq_mem_scheduler_if b ();

  lsq_mem_scheduler #(
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .clk_en    (clk_en),
    .bus       (b.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int ld_before;
  int ld_after;
  int stores;
  logic pop_seen;

  initial begin
    async_rst    = 1'b1;
    clk_en       = 1'b1;
    b.ld_valid   = 1'b1;
    b.ld_addr    = '0;
    b.ld_tag     = '0;
    b.st_valid   = 1'b0;
    b.st_commit  = 1'b0;
    b.st_addr    = '0;
    b.st_data    = '0;
    b.mem_gnt    = 1'b0;
    b.mem_rvalid = 1'b0;
    b.mem_rdata  = '0;

    // Reset state
    step(); step(); #1;
    chk("rst_mem_req", b.mem_req, 1'b0);
    chk("rst_ld_ready", b.ld_ready, 1'b0);
    chk("rst_pop", b.pop_queue, 1'b0);
    chk("rst_resp", b.ld_resp_valid, 1'b0);
    chk("rst_state", dut.state_q, StIdle);
    async_rst  = 1'b0;
    b.ld_valid = 1'b0;
    step();

    // T1: async reset while in RD_REQ
    b.ld_valid = 1'b1; b.ld_addr = 32'h40; b.ld_tag = 7'd1;
    #1 chk("t1_accept", b.ld_ready, 1'b1);
    step(); #1;
    chk("t1_rdreq", b.mem_req, 1'b1);
    chk("t1_busy_ready", b.ld_ready, 1'b0);
    b.ld_valid = 1'b0;
    async_rst  = 1'b1;
    #1;
    chk("t1_rst_req", b.mem_req, 1'b0);
    chk("t1_rst_state", dut.state_q, StIdle);
    b.ld_valid = 1'b1; b.mem_gnt = 1'b1; b.mem_rvalid = 1'b1;
    step(); #1;
    chk("t1_rst_ready", b.ld_ready, 1'b0);
    chk("t1_rst_resp", b.ld_resp_valid, 1'b0);
    async_rst = 1'b0; b.ld_valid = 1'b0; b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0;
    step(); #1;
    chk("t1_no_resp", b.ld_resp_valid, 1'b0);
    chk("t1_idle_req", b.mem_req, 1'b0);

    // T2: load 0x100 tag 5, grant after 2 cycles, data 3 cycles after grant
    b.ld_valid = 1'b1; b.ld_addr = 32'h100; b.ld_tag = 7'd5;
    #1 chk("t2_accept", b.ld_ready, 1'b1);
    step(); b.ld_valid = 1'b0; #1;
    chk("t2_req", b.mem_req, 1'b1);
    chk("t2_addr", b.mem_addr, 32'h100);
    chk("t2_we", b.mem_we, 1'b0);
    step(); #1 chk("t2_hold1", b.mem_req, 1'b1);
    step(); b.mem_gnt = 1'b1; #1 chk("t2_hold2", b.mem_req, 1'b1);
    step(); b.mem_gnt = 1'b0; #1;
    chk("t2_drop", b.mem_req, 1'b0);
    chk("t2_wait", dut.state_q, StRdWait);
    step(); #1 chk("t2_noresp1", b.ld_resp_valid, 1'b0);
    step(); b.mem_rvalid = 1'b1; b.mem_rdata = 32'hDEADBEEF;
    #1 chk("t2_noresp2", b.ld_resp_valid, 1'b0);
    step(); b.mem_rvalid = 1'b0; #1;
    chk("t2_resp", b.ld_resp_valid, 1'b1);
    chk("t2_data", b.ld_resp_data, 32'hDEADBEEF);
    chk("t2_tag", b.ld_resp_tag, 7'd5);
    chk("t2_idle", dut.state_q, StIdle);
    step(); #1 chk("t2_pulse_end", b.ld_resp_valid, 1'b0);

    // T3: committed store, immediate grant
    b.st_valid = 1'b1; b.st_commit = 1'b1; b.st_addr = 32'h200; b.st_data = 32'h1234;
    b.mem_gnt  = 1'b1;
    step(); #1;
    chk("t3_req", b.mem_req, 1'b1);
    chk("t3_we", b.mem_we, 1'b1);
    chk("t3_addr", b.mem_addr, 32'h200);
    chk("t3_wdata", b.mem_wdata, 32'h1234);
    chk("t3_nopop", b.pop_queue, 1'b0);
    step(); #1;
    chk("t3_pop", b.pop_queue, 1'b1);
    chk("t3_req_drop", b.mem_req, 1'b0);
    step();
    b.st_valid = 1'b0; b.st_commit = 1'b0; b.mem_gnt = 1'b0;
    #1;
    chk("t3_pop_once", b.pop_queue, 1'b0);
    chk("t3_no_reissue", b.mem_req, 1'b0);
    step(); #1 chk("t3_quiet", b.mem_req, 1'b0);

    // T4: continuous loads against a committed store
    b.st_valid = 1'b1; b.st_commit = 1'b1; b.st_addr = 32'h400; b.st_data = 32'hCAFE;
    b.ld_valid = 1'b1; b.mem_gnt = 1'b1; b.mem_rvalid = 1'b1; b.mem_rdata = 32'h0;
    ld_before = 0; ld_after = 0; stores = 0; pop_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      b.ld_addr = 32'h1000 + 32'(4 * i);
      #1;
      if (b.ld_ready) begin
        if (stores == 0) ld_before++;
        else ld_after++;
      end
      if (b.mem_req && b.mem_we) begin
        stores++;
        chk("t4_cnt_clr", dut.u_starve.cnt_q, 3'd0);
      end
      if (b.pop_queue) pop_seen = 1'b1;
      step();
      if (pop_seen) begin
        b.st_valid = 1'b0; b.st_commit = 1'b0;
      end
    end
    b.ld_valid = 1'b0;
    chk("t4_loads_before", ld_before, 4);
    chk("t4_stores", stores, 1);
    chk("t4_loads_after", ld_after, 5);
    chk("t4_cnt_end", dut.u_starve.cnt_q, 3'd0);
    step(); b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0;
    step(); #1 chk("t4_idle", dut.state_q, StIdle);

    // T5: same-address load must wait behind the committed store
    b.st_valid = 1'b1; b.st_commit = 1'b1; b.st_addr = 32'h300; b.st_data = 32'hAA;
    b.ld_valid = 1'b1; b.ld_addr = 32'h300; b.ld_tag = 7'd9; b.mem_gnt = 1'b1;
    #1 chk("t5_ld_blocked", b.ld_ready, 1'b0);
    step(); #1;
    chk("t5_st_first", b.mem_we, 1'b1);
    chk("t5_st_addr", b.mem_addr, 32'h300);
    step(); #1;
    chk("t5_pop", b.pop_queue, 1'b1);
    chk("t5_pop_noready", b.ld_ready, 1'b0);
    b.st_valid = 1'b0; b.st_commit = 1'b0;
    step(); #1 chk("t5_ld_accept", b.ld_ready, 1'b1);
    step(); b.ld_valid = 1'b0; #1;
    chk("t5_rd_req", b.mem_req, 1'b1);
    chk("t5_rd_we", b.mem_we, 1'b0);
    chk("t5_rd_addr", b.mem_addr, 32'h300);
    step(); b.mem_gnt = 1'b0; b.mem_rvalid = 1'b1; b.mem_rdata = 32'h55;
    step(); b.mem_rvalid = 1'b0; #1;
    chk("t5_resp", b.ld_resp_valid, 1'b1);
    chk("t5_data", b.ld_resp_data, 32'h55);
    chk("t5_tag", b.ld_resp_tag, 7'd9);
    step();

    // T6: clk_en freezes in RD_REQ and RD_WAIT
    b.ld_valid = 1'b1; b.ld_addr = 32'h500; b.ld_tag = 7'd3;
    #1 chk("t6_accept", b.ld_ready, 1'b1);
    step(); b.ld_valid = 1'b0; clk_en = 1'b0; b.mem_gnt = 1'b1;
    #1 chk("t6_req", b.mem_req, 1'b1);
    step(); #1;
    chk("t6_req_frozen", b.mem_req, 1'b1);
    chk("t6_state_frozen", dut.state_q, StRdReq);
    clk_en = 1'b1;
    step(); b.mem_gnt = 1'b0; #1;
    chk("t6_req_drop", b.mem_req, 1'b0);
    chk("t6_wait", dut.state_q, StRdWait);
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 3) b.mem_rvalid = 1'b1;
      #1;
      chk("t6_frz_state", dut.state_q, StRdWait);
      chk("t6_frz_req", b.mem_req, 1'b0);
      chk("t6_frz_resp", b.ld_resp_valid, 1'b0);
    end
    clk_en = 1'b1; b.mem_rvalid = 1'b0;
    step(); #1;
    chk("t6_rvalid_ignored", b.ld_resp_valid, 1'b0);
    chk("t6_still_wait", dut.state_q, StRdWait);
    b.mem_rvalid = 1'b1; b.mem_rdata = 32'h77;
    step(); b.mem_rvalid = 1'b0; clk_en = 1'b0;
    #1 chk("t6_pulse_masked", b.ld_resp_valid, 1'b0);
    step(); #1 chk("t6_pulse_masked2", b.ld_resp_valid, 1'b0);
    clk_en = 1'b1;
    #1;
    chk("t6_resp", b.ld_resp_valid, 1'b1);
    chk("t6_data", b.ld_resp_data, 32'h77);
    chk("t6_tag", b.ld_resp_tag, 7'd3);
    step(); #1 chk("t6_pulse_end", b.ld_resp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
